// File: rtl/read_in_pkg.sv
// read_in_pkg: definitions shared by the bank-A read path and the write path.
//   rd_state_e        run-controller state encoding (IDLE / READ / DRAIN)
//   ROW_WIDTH         bits per SRAM row (ARRAY_SIZE * OUTPUT_DATA_WIDTH)
//   SRAM_RD_ON/OFF    levels of the active-low SRAM read strobe
package read_in_pkg;

  localparam int ARRAY_SIZE        = 8;
  localparam int OUTPUT_DATA_WIDTH = 16;
  localparam int ROW_WIDTH         = ARRAY_SIZE * OUTPUT_DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2
  } rd_state_e;

  localparam logic SRAM_RD_ON  = 1'b0;
  localparam logic SRAM_RD_OFF = 1'b1;

endpackage

// File: rtl/read_in_if.sv
// read_in_if: row stream from the read path to its consumer.
//   out_valid  row present          out_ready  consumer accepts
//   out_data   row contents         out_index  row offset within the run
//   out_last   final row of the run
// master = producer (read_in), slave = consumer.
interface read_in_if #(
  parameter int ROW_WIDTH  = read_in_pkg::ROW_WIDTH,
  parameter int ADDR_WIDTH = 6
) ();
  logic                  out_valid;
  logic                  out_ready;
  logic [ROW_WIDTH-1:0]  out_data;
  logic [ADDR_WIDTH-1:0] out_index;
  logic                  out_last;

  modport master (output out_valid, out_data, out_index, out_last, input out_ready);
  modport slave  (input out_valid, out_data, out_index, out_last, output out_ready);
endinterface

// File: rtl/read_in_row_fifo.sv
// read_in_row_fifo: synchronous row FIFO, DEPTH x WIDTH, simultaneous push/pop.
//   clk, srst   clock, synchronous active-high reset (clears pointers/count)
//   push_i      write wdata_i (caller never pushes into a full FIFO)
//   pop_i       drop the head entry (ignored when empty)
//   head_o      current head entry
//   count_o     occupancy 0..DEPTH
//   empty_o     occupancy == 0
module read_in_row_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 128
) (
  input  logic                     clk,
  input  logic                     srst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [PW:0]   CNT_ONE = (PW + 1)'(1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [PW:0]      count_q;
  logic             pop_en;

  assign pop_en  = pop_i & (count_q != '0);
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign empty_o = (count_q == '0);

  // Storage carries no reset; only the pointers define what is valid.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (pop_en) rd_ptr_q <= rd_ptr_q + PTR_ONE;
      case ({push_i, pop_en})
        2'b10:   count_q <= count_q + CNT_ONE;
        2'b01:   count_q <= count_q - CNT_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/read_in.sv
// read_in: streams a run of consecutive bank-A SRAM rows to a consumer.
//   clk, srst                      clock, synchronous active-high reset
//   start, base_addr, row_count    run request (sampled only while idle)
//   busy, done                     run in progress / one-cycle completion pulse
//   sram_read_enable_a0            active-low read strobe (registered)
//   sram_raddr_a, sram_rdata_a     SRAM read address (registered) / read data
//   out_if                         row stream (valid/ready, data, index, last)
// Reads are issued ahead of the consumer and land in a small row FIFO two
// cycles later; issue is throttled so FIFO + in-flight rows never exceed
// FIFO_DEPTH.
module read_in
  import read_in_pkg::*;
#(
  parameter int ARRAY_SIZE        = 8,
  parameter int OUTPUT_DATA_WIDTH = 16,
  parameter int ADDR_WIDTH        = 6,
  parameter int FIFO_DEPTH        = 4
) (
  input  logic                                    clk,
  input  logic                                    srst,
  input  logic                                    start,
  input  logic [ADDR_WIDTH-1:0]                   base_addr,
  input  logic [ADDR_WIDTH:0]                     row_count,
  output logic                                    busy,
  output logic                                    done,
  output logic                                    sram_read_enable_a0,
  output logic [ADDR_WIDTH-1:0]                   sram_raddr_a,
  input  logic [ARRAY_SIZE*OUTPUT_DATA_WIDTH-1:0] sram_rdata_a,
  read_in_if.master                               out_if
);
  localparam int RW = ARRAY_SIZE * OUTPUT_DATA_WIDTH;
  localparam int AW = ADDR_WIDTH;
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
  localparam logic [AW-1:0] IDX_ONE = AW'(1);
  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(FIFO_DEPTH);

  rd_state_e     state_q;
  logic [AW-1:0] base_q, raddr_q, idx_q;
  logic [AW:0]   count_q, issued_q;
  logic          v1_q, v2_q, ren_q, busy_q, done_q;

  logic [CW-1:0] fifo_count;
  logic [RW-1:0] fifo_head;
  logic          fifo_empty;
  logic          pop_d, issue_d, last_d;
  logic [CW:0]   occ_d;

  assign pop_d  = ~fifo_empty & out_if.out_ready;
  assign last_d = (({1'b0, idx_q} + CNT_ONE) == count_q);

  // Rows that will occupy the FIFO after this edge: stored + strobed (v1) +
  // sampled (v2) - the one leaving now. A new read is only issued if it fits.
  assign occ_d   = {1'b0, fifo_count} + {{CW{1'b0}}, v1_q} + {{CW{1'b0}}, v2_q}
                 - {{CW{1'b0}}, pop_d};
  assign issue_d = (state_q == ST_READ) && (issued_q < count_q) && (occ_d < DEPTH_C);

  read_in_row_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (RW)
  ) u_row_fifo (
    .clk     (clk),
    .srst    (srst),
    .push_i  (v2_q),
    .wdata_i (sram_rdata_a),
    .pop_i   (pop_d),
    .head_o  (fifo_head),
    .count_o (fifo_count),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk) begin
    if (srst) begin
      state_q  <= ST_IDLE;
      base_q   <= '0;
      count_q  <= '0;
      issued_q <= '0;
      idx_q    <= '0;
      v1_q     <= 1'b0;
      v2_q     <= 1'b0;
      ren_q    <= SRAM_RD_OFF;
      raddr_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      v1_q   <= issue_d;
      v2_q   <= v1_q;
      if (issue_d) begin
        ren_q    <= SRAM_RD_ON;
        raddr_q  <= base_q + issued_q[AW-1:0];  // wraps modulo 2^AW
        issued_q <= issued_q + CNT_ONE;
      end else begin
        ren_q <= SRAM_RD_OFF;
      end
      if (pop_d) idx_q <= idx_q + IDX_ONE;

      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (row_count != '0) begin
              base_q   <= base_addr;
              count_q  <= row_count;
              issued_q <= '0;
              idx_q    <= '0;
              busy_q   <= 1'b1;
              state_q  <= ST_READ;
            end else begin
              done_q <= 1'b1;  // empty run: acknowledge without SRAM access
            end
          end
        end
        ST_READ: begin
          if (issued_q == count_q) state_q <= ST_DRAIN;
        end
        ST_DRAIN: begin
          if (pop_d && last_d) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy                = busy_q;
  assign done                = done_q;
  assign sram_read_enable_a0 = ren_q;
  assign sram_raddr_a        = raddr_q;

  // Data is forced to zero when empty so stale FIFO contents never show.
  assign out_if.out_valid = ~fifo_empty;
  assign out_if.out_data  = fifo_empty ? '0 : fifo_head;
  assign out_if.out_index = idx_q;
  assign out_if.out_last  = ~fifo_empty & last_d;

endmodule

// File: tb/tb_read_in.sv
// tb_read_in: scoreboard bench for read_in. Stimulus pushes expected rows and
// read addresses into queues; a negedge monitor pops and compares them.
module tb_read_in;
  localparam int RW    = 128;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic [RW-1:0] data;
    logic [5:0]    idx;
    logic          last;
  } exp_t;

  logic          clk, srst, start, busy, done, sram_read_enable_a0;
  logic [5:0]    base_addr, sram_raddr_a;
  logic [6:0]    row_count;
  logic [RW-1:0] sram_rdata_a;
  logic [RW-1:0] mem [64];

  exp_t       exp_q [$];
  logic [5:0] addr_q [$];
  int vectors = 0, miscompares = 0, xfer_cnt = 0;
  int issued_cnt = 0, consumed_cnt = 0;
  bit ready_mode = 0;

  read_in_if #(.ROW_WIDTH(RW), .ADDR_WIDTH(6)) bus ();

  read_in dut (
    .clk                 (clk),
    .srst                (srst),
    .start               (start),
    .base_addr           (base_addr),
    .row_count           (row_count),
    .busy                (busy),
    .done                (done),
    .sram_read_enable_a0 (sram_read_enable_a0),
    .sram_raddr_a        (sram_raddr_a),
    .sram_rdata_a        (sram_rdata_a),
    .out_if              (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM model: samples the strobe/address at an edge, data valid until the next read.
  always @(posedge clk) begin
    if (!sram_read_enable_a0) sram_rdata_a <= mem[sram_raddr_a];
  end

  function automatic logic [RW-1:0] row_of(input int k);
    logic [15:0] e;
    e = 16'(k) * 16'h0101;
    return {8{e}};
  endfunction

  task automatic chk(input string nm, input logic [RW-1:0] act, input logic [RW-1:0] expv);
    vectors++;
    if (act !== expv) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Consumer ready: always 1, or a fixed stall pattern.
  initial begin
    logic [15:0] pat;
    int pat_i;
    pat = 16'b1001_1010_0110_0101;
    pat_i = 0;
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #2;
      if (ready_mode) begin
        bus.out_ready = pat[pat_i];
        pat_i = (pat_i + 1) % 16;
      end else begin
        bus.out_ready = 1'b1;
      end
    end
  end

  // Monitor: values at negedge are what the DUT samples at the next posedge.
  initial begin
    bit done_exp, prev_stall;
    logic [RW-1:0] hold_data;
    logic [5:0] hold_idx;
    logic hold_last;
    exp_t e;
    logic [5:0] a;
    done_exp = 0;
    prev_stall = 0;
    forever begin
      @(negedge clk);
      if (srst) begin
        done_exp = 0;
        prev_stall = 0;
        issued_cnt = 0;
        consumed_cnt = 0;
      end else begin
        if (done_exp || done) chk("done_pulse", done, done_exp);
        done_exp = start && !busy && (row_count == 0);
        if (prev_stall && bus.out_valid) begin
          chk("stall_data", bus.out_data, hold_data);
          chk("stall_index", bus.out_index, hold_idx);
          chk("stall_last", bus.out_last, hold_last);
        end
        if (!sram_read_enable_a0) begin
          issued_cnt++;
          chk("read_expected", addr_q.size() > 0, 1);
          if (addr_q.size() > 0) begin
            a = addr_q.pop_front();
            chk("raddr", sram_raddr_a, a);
          end
          chk("lookahead", (issued_cnt - consumed_cnt) <= DEPTH, 1);
        end
        if (bus.out_valid && bus.out_ready) begin
          xfer_cnt++;
          consumed_cnt++;
          chk("row_expected", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("row_data", bus.out_data, e.data);
            chk("row_index", bus.out_index, e.idx);
            chk("row_last", bus.out_last, e.last);
            if (e.last) done_exp = 1;
          end
        end
        prev_stall = bus.out_valid && !bus.out_ready;
        hold_data = bus.out_data;
        hold_idx = bus.out_index;
        hold_last = bus.out_last;
      end
    end
  end

  // Called at posedge+1; returns one cycle later (start has been sampled).
  task automatic launch(input int b, input int c, input bit lat);
    for (int i = 0; i < c; i++) begin
      exp_t e;
      int ad;
      ad = (b + i) % 64;
      e.data = row_of(ad);
      e.idx  = 6'(i);
      e.last = (i == c - 1);
      exp_q.push_back(e);
      addr_q.push_back(6'(ad));
    end
    start = 1'b1;
    base_addr = 6'(b);
    row_count = 7'(c);
    @(posedge clk); #1;
    start = 1'b0;
    if (lat) begin
      chk("busy_after_start", busy, 1);
      chk("valid_e0", bus.out_valid, 0);
      @(posedge clk); #1;
      chk("strobe_e1", sram_read_enable_a0, 0);
      chk("addr_e1", sram_raddr_a, 6'(b));
      @(posedge clk); #1;
      chk("valid_e2", bus.out_valid, 0);
      @(posedge clk); #1;
      chk("valid_e3", bus.out_valid, 1);
      chk("data_e3", bus.out_data, row_of(b));
    end
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    while (!done && n < 400) begin
      @(posedge clk); #1;
      n++;
    end
    chk("done_seen", done, 1);
    chk("busy_at_done", busy, 0);
    @(posedge clk); #1;
    chk("rows_left", exp_q.size(), 0);
    chk("reads_left", addr_q.size(), 0);
  endtask

  task automatic check_reset_state();
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_strobe", sram_read_enable_a0, 1);
    chk("rst_raddr", sram_raddr_a, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_index", bus.out_index, 0);
    chk("rst_last", bus.out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0, n;
    for (int k = 0; k < 64; k++) mem[k] = row_of(k);
    srst = 1'b1;
    start = 1'b0;
    base_addr = '0;
    row_count = '0;
    repeat (2) @(posedge clk);
    #1;
    check_reset_state();
    srst = 1'b0;
    @(posedge clk); #1;

    // Basic run with first-row latency checks.
    launch(0, 8, 1);
    wait_done();

    // Address wrap past 63.
    launch(60, 8, 0);
    wait_done();

    // Consumer back-pressure.
    ready_mode = 1;
    launch(0, 8, 0);
    wait_done();
    ready_mode = 0;

    // Empty run.
    launch(7, 0, 0);
    wait_done();
    chk("zero_valid", bus.out_valid, 0);
    chk("zero_strobe", sram_read_enable_a0, 1);

    // Reset after the third transfer.
    x0 = xfer_cnt;
    launch(5, 8, 0);
    n = 0;
    while (xfer_cnt < x0 + 3 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("third_xfer_seen", xfer_cnt >= x0 + 3, 1);
    srst = 1'b1;
    exp_q.delete();
    addr_q.delete();
    @(posedge clk); #1;
    check_reset_state();
    srst = 1'b0;
    launch(10, 2, 0);
    wait_done();

    // start while busy is ignored.
    launch(20, 6, 0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    start = 1'b1;
    base_addr = 6'd40;
    row_count = 7'd3;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done();

    // Full 64-row run with wrap.
    launch(17, 64, 0);
    wait_done();

    repeat (10) @(posedge clk);
    #1;
    chk("idle_valid", bus.out_valid, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
